counter_stream_gen: RTL and testbench
=====================================

Name: counter_stream_gen

Overview:
- Synthesizable, parametrised successor to the simulation counter source.
- Emits NUM_SLICE x NUM_COUNTER counter words per run on a valid/ready stream, then idles at zero.
- Generates random, incrementing or constant values from a seeded LFSR.
- Tags every word with slice/counter indices and a Last flag; feeds the sketch/slice ingest logic in both simulation and hardware builds.

Parameters:
- NUM_COUNTER, 10, counters per slice (>=1).
- NUM_SLICE, 2, slices per run (>=1).
- DATA_W, 32, width of Counter and Const_Val (8..32).
- MAX_VAL, 100, upper bound of random values, which lie in 1..MAX_VAL (1 <= MAX_VAL < 2^DATA_W).
- SEED, 32'hACE12468, LFSR reset/reload value (nonzero).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- Mode  in  2  0 random, 1 incrementing, 2 constant, 3 reserved (outputs 0); sampled on Start.
- Const_Val  in  DATA_W  value for mode 2; sampled on Start.
- Out_Ready  in  1  downstream accept.
- Out_Valid  out  1  Counter holds a valid word.
- Counter  out  DATA_W  data word; 0 whenever Out_Valid=0.
- Slice_Idx  out  SW=$clog2(NUM_SLICE+1)  slice of current word.
- Counter_Idx  out  CW=$clog2(NUM_COUNTER+1)  counter within slice.
- Last  out  1  high with the final word of a run.
- Busy  out  1  high in LOAD and SEND.
- Done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, any state): FSM=IDLE; LFSR=SEED; all outputs 0; latched Mode/Const_Val cleared. A run in progress is abandoned with no Done pulse.
- FSM states:
  - IDLE: Start=1 latches Mode/Const_Val, clears the indices, goes to LOAD. Start=0 stays in IDLE.
  - LOAD (1 cycle): first word is registered; Out_Valid=1 from the next cycle (Start-to-Out_Valid latency 2 cycles); goes to SEND.
  - SEND: on Out_Valid & Out_Ready, advances to the next word in the same cycle, giving full throughput with Ready tied high. After the handshake of the Last word, goes to DONE.
  - DONE (1 cycle): Done=1, Out_Valid=0, Counter=0, Busy=0; goes to IDLE.
- Stream rules:
  - While Out_Valid & !Out_Ready, Counter/indices/Last are held stable and the LFSR does not step.
  - Out_Valid never drops without a handshake, except on Reset.
  - Start is ignored outside IDLE.
- Word order: Counter_Idx is the inner loop 0..NUM_COUNTER-1; Slice_Idx is the outer loop 0..NUM_SLICE-1; global index g = Slice_Idx*NUM_COUNTER + Counter_Idx. Last = (g == NUM_SLICE*NUM_COUNTER-1).
- LFSR: 32-bit Galois, mask 32'h80200003. Step: shift right 1; if the old bit0 was 1, XOR the result with the mask. Steps once when each word is registered (LOAD and each SEND handshake), only in mode 0. Not reseeded between runs, so consecutive runs differ.
- Values per mode:
  - Mode 0: 1 + (lfsr_after_step % MAX_VAL), truncated to DATA_W.
  - Mode 1: g+1.
  - Mode 2: Const_Val.
  - Mode 3: 0, with handshakes still occurring.
- Single-word run (NUM_SLICE=NUM_COUNTER=1): Last is high on the first word.

Test Plan:
1. NUM_COUNTER=3, NUM_SLICE=2, Mode=1, Ready=1, Start at cycle 0 -> Out_Valid cycles 2..7; Counter 1,2,3,4,5,6; (Slice,Counter) (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); Last at cycle 7; Done at cycle 8; Counter=0 after.
2. Same config, Ready low for 3 cycles while word 2 (Counter=2) is presented -> word, indices and Last stable for all 3 stall cycles; total 6 handshakes; no duplicated or skipped values.
3. Mode=0, defaults (20 words), Ready=1 -> every Counter in [1,100]; sequence matches the bench LFSR model from SEED 32'hACE12468; a second run continues the sequence and does not repeat it.
4. Mode=2, Const_Val=32'hDEADBEEF -> 20 words of DEADBEEF; Start pulses issued mid-run are ignored; Done fires once.
5. Reset asserted during word 5 of a Mode=0 run with Ready=1 -> Out_Valid, Busy and Counter go 0 immediately (asynchronously); no Done; a new Start reproduces the first-run sequence from SEED.
6. NUM_SLICE=NUM_COUNTER=1, Mode=3 -> one word, Counter=0 with Out_Valid=1 and Last=1, then Done.

Source files
------------

// File: rtl/counter_stream_gen_if.sv
// Valid/ready stream carrying counter words tagged with slice/counter indices and a last flag.
interface counter_stream_gen_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SW     = 2,
  parameter int unsigned CW     = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [SW-1:0]     slice_idx;
  logic [CW-1:0]     counter_idx;
  logic              last;

  modport master (output valid, data, slice_idx, counter_idx, last, input ready);
  modport slave  (input valid, data, slice_idx, counter_idx, last, output ready);
endinterface

// File: rtl/counter_stream_gen.sv
// Streams NUM_SLICE x NUM_COUNTER counter words per run (random, incrementing or constant),
// tagging each with its slice/counter position and a last flag.
module counter_stream_gen #(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned NUM_SLICE   = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_VAL     = 100,
  parameter logic [31:0] SEED        = 32'hACE12468
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [DATA_W-1:0]         const_val_i,
  counter_stream_gen_if.master      out_if,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned SW       = $clog2(NUM_SLICE + 1);
  localparam int unsigned CW       = $clog2(NUM_COUNTER + 1);
  localparam int unsigned Total    = NUM_SLICE * NUM_COUNTER;
  localparam int unsigned GW       = $clog2(Total + 1);
  localparam logic [31:0] LfsrMask = 32'h80200003;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_step, rnd_val;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] const_q, const_d, data_q, data_d;
  logic [SW-1:0]     slice_q, slice_d;
  logic [CW-1:0]     cidx_q, cidx_d;
  logic [GW-1:0]     g_q, g_d;
  logic              last_q, last_d;
  logic              load_word;

  always_comb begin
    lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'd0);
    rnd_val   = (lfsr_step % MAX_VAL) + 32'd1;
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    const_d   = const_q;
    data_d    = data_q;
    slice_d   = slice_q;
    cidx_d    = cidx_q;
    g_d       = g_q;
    last_d    = last_q;
    load_word = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          const_d = const_val_i;
          slice_d = '0;
          cidx_d  = '0;
          g_d     = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_word = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        // Out_Valid is always high here, so ready alone completes the handshake.
        if (out_if.ready) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            load_word = 1'b1;
            g_d       = g_q + GW'(1);
            if (cidx_q == CW'(NUM_COUNTER - 1)) begin
              cidx_d  = '0;
              slice_d = slice_q + SW'(1);
            end else begin
              cidx_d  = cidx_q + CW'(1);
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Register the word addressed by the next-state indices.
    if (load_word) begin
      if (mode_q == 2'd0) lfsr_d = lfsr_step;
      case (mode_q)
        2'd0:    data_d = rnd_val[DATA_W-1:0];
        2'd1:    data_d = DATA_W'(32'(g_d) + 32'd1);
        2'd2:    data_d = const_q;
        default: data_d = '0;
      endcase
      last_d = (32'(g_d) == Total - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      mode_q  <= '0;
      const_q <= '0;
      data_q  <= '0;
      slice_q <= '0;
      cidx_q  <= '0;
      g_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      const_q <= const_d;
      data_q  <= data_d;
      slice_q <= slice_d;
      cidx_q  <= cidx_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    out_if.valid       = (state_q == StSend);
    out_if.data        = out_if.valid ? data_q : '0;
    out_if.slice_idx   = out_if.valid ? slice_q : '0;
    out_if.counter_idx = out_if.valid ? cidx_q : '0;
    out_if.last        = out_if.valid & last_q;
    busy_o             = (state_q == StLoad) || (state_q == StSend);
    done_o             = (state_q == StDone);
  end

endmodule

// File: tb/tb_counter_stream_gen.sv
// Scoreboard bench: three instances (10x2, 3x2, 1x1) checked against a word-list model of each run.
module tb_counter_stream_gen;

  typedef struct {
    logic [31:0] data;
    int          sl;
    int          ci;
    bit          last;
  } exp_t;

  localparam logic [31:0] Seed = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [1:0]  mode;
  logic [31:0] cval;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  always #5 clk = ~clk;

  counter_stream_gen_if #(.DATA_W(32), .SW(2), .CW(4)) ifa ();
  counter_stream_gen_if #(.DATA_W(32), .SW(2), .CW(2)) ifb ();
  counter_stream_gen_if #(.DATA_W(32), .SW(1), .CW(1)) ifc ();

  counter_stream_gen u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .mode_i(mode), .const_val_i(cval),
    .out_if(ifa.master), .busy_o(busy_a), .done_o(done_a)
  );
  counter_stream_gen #(.NUM_COUNTER(3), .NUM_SLICE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .mode_i(mode), .const_val_i(cval),
    .out_if(ifb.master), .busy_o(busy_b), .done_o(done_b)
  );
  counter_stream_gen #(.NUM_COUNTER(1), .NUM_SLICE(1)) u_dut_c (
    .clk(clk), .rst(rst), .start_i(start_c), .mode_i(mode), .const_val_i(cval),
    .out_if(ifc.master), .busy_o(busy_c), .done_o(done_c)
  );

  exp_t        q0[$], q1[$], q2[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          pops[3] = '{0, 0, 0};
  int          done_cnt[3] = '{0, 0, 0};
  bit          hv[3] = '{0, 0, 0};
  logic [31:0] hd[3];
  int          hs[3], hc[3];
  bit          hl[3];
  logic [31:0] m_lfsr = Seed;
  bit          rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic exp_t q_pop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Expected word list of a whole run, built from the position/mode rules.
  task automatic push_run(input int d, input int md, input logic [31:0] cv);
    int nc, ns;
    exp_t e;
    nc = (d == 0) ? 10 : (d == 1) ? 3 : 1;
    ns = (d == 2) ? 1 : 2;
    for (int g = 0; g < ns * nc; g++) begin
      case (md)
        0: begin
          m_lfsr = lfsr_next(m_lfsr);
          e.data = (m_lfsr % 32'd100) + 32'd1;
        end
        1:       e.data = 32'(g + 1);
        2:       e.data = cv;
        default: e.data = 32'd0;
      endcase
      e.sl   = g / nc;
      e.ci   = g % nc;
      e.last = (g == ns * nc - 1);
      q_push(d, e);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [31:0] dat,
                     input int sl, input int ci, input logic lst, input logic dn);
    exp_t e;
    if (!v) chk("idle_counter_zero", dat, 32'd0);
    if (hv[d]) begin
      chk("stall_valid_held", 32'(v), 32'd1);
      chk("stall_data_held", dat, hd[d]);
      chk("stall_slice_held", sl, hs[d]);
      chk("stall_cidx_held", ci, hc[d]);
      chk("stall_last_held", 32'(lst), 32'(hl[d]));
    end
    if (v && r) begin
      if (q_size(d) == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = q_pop(d);
        pops[d]++;
        chk("word_data", dat, e.data);
        chk("word_slice", sl, e.sl);
        chk("word_cidx", ci, e.ci);
        chk("word_last", 32'(lst), 32'(e.last));
      end
    end
    hv[d] = v && !r;
    hd[d] = dat;
    hs[d] = sl;
    hc[d] = ci;
    hl[d] = lst;
    if (dn) begin
      done_cnt[d]++;
      chk("done_with_words_left", q_size(d), 0);
      chk("done_while_valid", 32'(v), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.valid, ifa.ready, ifa.data, 32'(ifa.slice_idx), 32'(ifa.counter_idx),
          ifa.last, done_a);
      mon(1, ifb.valid, ifb.ready, ifb.data, 32'(ifb.slice_idx), 32'(ifb.counter_idx),
          ifb.last, done_b);
      mon(2, ifc.valid, ifc.ready, ifc.data, 32'(ifc.slice_idx), 32'(ifc.counter_idx),
          ifc.last, done_c);
    end
  end

  task automatic go(input int d, input logic [1:0] md, input logic [31:0] cv);
    @(negedge clk);
    mode = md;
    cval = cv;
    push_run(d, int'(md), cv);
    if (d == 0) start_a = 1'b1;
    else if (d == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int s;
    s = done_cnt[d];
    for (int i = 0; i < 400 && done_cnt[d] == s; i++) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) ifa.ready = 1'($urandom_range(0, 1));
    end
    ifa.ready = 1'b1;
    chk("done_seen", done_cnt[d] - s, 32'd1);
  endtask

  initial begin
    int p, cyc, dc;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode = 2'd0; cval = 32'd0;
    ifa.ready = 1'b1; ifb.ready = 1'b1; ifc.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(ifa.valid), 32'd0);
    chk("reset_busy", 32'(busy_a | busy_b | busy_c), 32'd0);
    chk("reset_done", 32'(done_a | done_b | done_c), 32'd0);
    chk("reset_counter", ifa.data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Incrementing run on 3x2: latency and Done timing.
    p = pops[1];
    go(1, 2'd1, 32'd0);
    chk("load_busy", 32'(busy_b), 32'd1);
    chk("load_no_valid", 32'(ifb.valid), 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid_latency", 32'(ifb.valid), 32'd1);
    cyc = 1;
    while (!done_b && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_latency", cyc, 7);
    @(posedge clk);
    #1;
    chk("after_done_pulse", 32'(done_b), 32'd0);
    chk("after_done_valid", 32'(ifb.valid), 32'd0);
    chk("after_done_busy", 32'(busy_b), 32'd0);
    chk("after_done_counter", ifb.data, 32'd0);
    chk("run1_handshakes", pops[1] - p, 32'd6);

    // Three-cycle stall while the second word is presented.
    p = pops[1];
    go(1, 2'd1, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    ifb.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ifb.ready = 1'b1;
    wait_done(1);
    chk("stall_handshakes", pops[1] - p, 32'd6);

    // Random mode: two runs, the second with random ready, continuing the LFSR.
    go(0, 2'd0, 32'd0);
    wait_done(0);
    rnd_rdy = 1'b1;
    go(0, 2'd0, 32'd0);
    wait_done(0);
    rnd_rdy = 1'b0;

    // Constant mode with Start pulses mid-run.
    dc = done_cnt[0];
    go(0, 2'd2, 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    mode = 2'd1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done(0);
    repeat (3) @(posedge clk);
    chk("const_done_once", done_cnt[0] - dc, 32'd1);

    rnd_rdy = 1'b1;
    go(0, 2'd1, 32'd0);
    wait_done(0);
    rnd_rdy = 1'b0;

    // Reset during the fifth word of a random run.
    p = pops[0];
    go(0, 2'd0, 32'd0);
    for (int i = 0; i < 100 && pops[0] < p + 5; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reset_point_reached", pops[0] - p, 32'd5);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 32'(ifa.valid), 32'd0);
    chk("async_reset_busy", 32'(busy_a), 32'd0);
    chk("async_reset_counter", ifa.data, 32'd0);
    q0.delete();
    m_lfsr = Seed;
    dc = done_cnt[0];
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("no_done_after_reset", done_cnt[0], dc);
    go(0, 2'd0, 32'd0);
    wait_done(0);

    // Single-word run, reserved mode.
    p = pops[2];
    go(2, 2'd3, 32'h12345678);
    wait_done(2);
    chk("single_word_handshakes", pops[2] - p, 32'd1);

    repeat (3) @(posedge clk);
    chk("queue_a_empty", q_size(0), 0);
    chk("queue_b_empty", q_size(1), 0);
    chk("queue_c_empty", q_size(2), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
